tx_pause_gen: RTL and testbench
===============================

# tx_pause_gen

Transmit-side IEEE 802.3x PAUSE frame generator for the 10G MAC, on the 64-bit AXIS path ahead of the TX framer (FCS appended downstream). It inserts XOFF frames (configured quanta) and XON frames (quanta 0) between user frames when local flow control is requested. It refreshes XOFF periodically while the request is held. Its frames are exactly the format the RX pause detector decodes.

## Interface
- Parameters: none; all configuration via cfg_* ports.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_tdata/s_tkeep/s_tvalid/s_tlast  in  64/8/1/1  user frame stream
- s_tready  out  1  user stream ready
- m_tdata/m_tkeep/m_tvalid/m_tlast  out  64/8/1/1  merged stream to TX MAC
- m_tready  in  1  MAC ready
- xoff_req  in  1  level; high = ask link partner to pause
- cfg_tx_pause_enable  in  1  enables generation
- cfg_src_mac  in  48  SA; [47:40] is first byte on wire
- cfg_pause_quanta  in  16  XOFF quanta
- cfg_refresh_count  in  16  cycles between XOFF refreshes; 0 = no refresh
- pause_sent  out  1  one-cycle pulse on acceptance of a pause frame's last beat
- xoff_active  out  1  high after an XOFF frame is sent until an XON frame is sent

## Operation
- Byte n of a beat is tdata[8n+7:8n]; byte 0 is first on wire.
- Frame: 8 beats (60 bytes).
  - Beat0: 01 80 C2 00 00 01, SA[47:40], SA[39:32]; tdata[47:0] = 48'h010000C28001.
  - Beat1: SA bytes 2-5, 88 08, 00 01.
  - Beat2: quanta MSB, quanta LSB, then zeros.
  - Beats 3-7: zeros.
  - tkeep = 8'hFF, except beat7 = 8'h0F with tlast.
- States:
  - S_IDLE: if a frame is pending and enable=1 -> S_PAUSE; quanta latched: XOFF = cfg_pause_quanta, XON = 16'h0000. Otherwise pass through. On s_tvalid & m_tready & !s_tlast -> S_USER.
  - S_USER: pass through; on s_tvalid & m_tready & s_tlast -> S_IDLE.
  - S_PAUSE: s_tready = 0. m_tvalid = 1. The 3-bit beat counter advances on m_tready. On beat 7 accepted -> S_IDLE, pause_sent pulses, the serviced pending flag clears.
- Pass-through is combinational: m_* = s_*, s_tready = m_tready.
- A pause frame never interrupts a user frame.
- Pending logic, using registered xoff_req history:
  - Rising edge: xoff_pend = 1, xon_pend = 0.
  - Falling edge: xon_pend = xoff_active, xoff_pend = 0.
  - Refresh: a 16-bit timer reloads cfg_refresh_count when an XOFF frame completes. It decrements each cycle while xoff_req=1, xoff_active=1, and cfg_refresh_count≠0. On reaching 1 it sets xoff_pend.
  - XON has priority over XOFF if both are pending.
- Edges or refresh expiry during S_PAUSE are recorded and served next idle; the latched quanta does not change mid-frame.
- cfg_tx_pause_enable = 0:
  - clears pendings and the refresh timer;
  - blocks new frames;
  - a frame in progress completes.
- xoff_active: set on XOFF completion, cleared on XON completion.

## Timing
- Reset values:
  - state S_IDLE, beat counter 0, pendings 0;
  - xoff_active 0, pause_sent 0, timer 0;
  - xoff_req history register 0, so xoff_req held high through reset yields a rising edge on the first cycle after reset.
- While rst=1: m_tvalid = 0, s_tready = 0.
- rst mid-frame aborts the frame (MAC-wide reset).
- Pending set at edge N+1 (registered). A frame starts in S_IDLE no earlier than N+2. Eight beats take 8 cycles with m_tready held high.
- m_tvalid in S_PAUSE never deasserts before acceptance. m_tdata/m_tkeep are stable while m_tready = 0.
- Backpressure on user traffic is passed through unchanged; zero added latency.

## Test plan
- xoff_req rises, idle link, m_tready=1, cfg_pause_quanta=16'h1234 → 8 beats. Beat0 tdata[47:0]=48'h010000C28001; beat1 tdata[63:32]=32'h01000888; beat2 tdata[15:0]=16'h3412; beat7 tkeep=8'h0F, tlast; pause_sent pulse; xoff_active=1.
- xoff_req rises mid user frame (beat 3 of 10) → user frame completes intact with s_tready following m_tready. The pause frame follows immediately; the next user frame is held (s_tready=0) for 8 cycles.
- xoff_req held, cfg_refresh_count=100 → XOFF frames repeat every 100 cycles plus frame time. The falling edge yields one XON with beat2 tdata[15:0]=0; xoff_active=0.
- xoff_req pulses high 1 cycle then low, with no XOFF yet sent → no frame emitted: the rising edge's XOFF pending is cancelled by the falling edge, and no XON is pending since xoff_active=0.
- Random m_tready toggling during pause frame → beat data stable under stall; exactly 8 accepted beats.
- cfg_tx_pause_enable=0 with xoff_req toggling → no pause frames, pure pass-through. rst asserted mid-pause-frame → m_tvalid=0, all outputs at reset values next cycle.

Source files
------------

// File: rtl/tx_pause_gen.sv
// tx_pause_gen
// Inserts 802.3x PAUSE frames (XOFF with configured quanta, XON with quanta 0)
// between user frames on the 64-bit AXIS path ahead of the TX framer. The FCS
// is appended downstream, so frames are 60 bytes over 8 beats.
//
// State table:
//   S_IDLE  | between frames; passes user traffic unless a pause frame launches
//   S_USER  | inside a user frame; pure pass-through until its tlast beat
//   S_PAUSE | emitting the 8-beat pause frame, user stream held off
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_t*                     user frame stream in (s_tready out)
//   m_t*                     merged stream to the TX MAC (m_tready in)
//   xoff_req                 level request to pause the link partner
//   cfg_tx_pause_enable      generation enable
//   cfg_src_mac              source address, [47:40] first on the wire
//   cfg_pause_quanta         quanta carried by XOFF frames
//   cfg_refresh_count        cycles between XOFF refreshes, 0 = no refresh
//   pause_sent               pulse after a pause frame's last beat is accepted
//   xoff_active              high from XOFF completion until XON completion
module tx_pause_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_tdata,
  input  logic [7:0]  s_tkeep,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  input  logic        xoff_req,
  input  logic        cfg_tx_pause_enable,
  input  logic [47:0] cfg_src_mac,
  input  logic [15:0] cfg_pause_quanta,
  input  logic [15:0] cfg_refresh_count,
  output logic        pause_sent,
  output logic        xoff_active
);

  typedef enum logic [1:0] {S_IDLE, S_USER, S_PAUSE} state_t;

  state_t      state_q;
  logic [2:0]  beat_q;
  logic        req_q;
  logic        xoff_pend_q;
  logic        xon_pend_q;
  logic        xoff_active_q;
  logic        pause_sent_q;
  logic        is_xon_q;
  logic [15:0] quanta_q;
  logic [15:0] timer_q;

  logic        req_rise;
  logic        req_fall;
  logic        refresh_run;
  logic        refresh_hit;
  logic        frame_done;
  logic        xoff_active_d;
  logic        xoff_pend_d;
  logic        xon_pend_d;
  logic        start;
  logic        launch;
  logic [63:0] pause_data;
  logic [7:0]  pause_keep;

  assign req_rise    = xoff_req & ~req_q;
  assign req_fall    = ~xoff_req & req_q;
  assign refresh_run = xoff_req & xoff_active_q & (cfg_refresh_count != 16'h0000);
  assign refresh_hit = refresh_run & (timer_q == 16'd1);
  assign frame_done  = (state_q == S_PAUSE) & m_tready & (beat_q == 3'd7);

  assign xoff_active_d = frame_done ? ~is_xon_q : xoff_active_q;

  // Pending flags after this cycle's events; later events override earlier ones.
  always_comb begin
    xoff_pend_d = xoff_pend_q;
    xon_pend_d  = xon_pend_q;
    if (frame_done) begin
      if (is_xon_q) xon_pend_d  = 1'b0;
      else          xoff_pend_d = 1'b0;
    end
    if (refresh_hit) xoff_pend_d = 1'b1;
    if (req_rise) begin
      xoff_pend_d = 1'b1;
      xon_pend_d  = 1'b0;
    end
    if (req_fall) begin
      xoff_pend_d = 1'b0;
      xon_pend_d  = xoff_active_d;
    end
  end

  // A frame launches only if something was pending and is not being cancelled
  // this very cycle, so a one-cycle xoff_req pulse produces nothing.
  assign start  = cfg_tx_pause_enable & (xoff_pend_q | xon_pend_q) & (xoff_pend_d | xon_pend_d);
  assign launch = start & ((state_q == S_IDLE) |
                  ((state_q == S_USER) & s_tvalid & m_tready & s_tlast));

  always_comb begin
    pause_data = 64'h0;
    case (beat_q)
      3'd0: pause_data = {cfg_src_mac[39:32], cfg_src_mac[47:40], 48'h0100_00C2_8001};
      3'd1: pause_data = {32'h0100_0888, cfg_src_mac[7:0], cfg_src_mac[15:8],
                          cfg_src_mac[23:16], cfg_src_mac[31:24]};
      3'd2: pause_data = {48'h0, quanta_q[7:0], quanta_q[15:8]};
      default: pause_data = 64'h0;
    endcase
    pause_keep = (beat_q == 3'd7) ? 8'h0F : 8'hFF;
  end

  always_comb begin
    m_tdata  = s_tdata;
    m_tkeep  = s_tkeep;
    m_tvalid = s_tvalid;
    m_tlast  = s_tlast;
    s_tready = m_tready;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_tvalid = 1'b0;
          s_tready = 1'b0;
        end
      end
      S_PAUSE: begin
        m_tdata  = pause_data;
        m_tkeep  = pause_keep;
        m_tvalid = 1'b1;
        m_tlast  = (beat_q == 3'd7);
        s_tready = 1'b0;
      end
      default: ;
    endcase
    if (rst) begin
      m_tvalid = 1'b0;
      s_tready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      beat_q        <= 3'd0;
      req_q         <= 1'b0;
      xoff_pend_q   <= 1'b0;
      xon_pend_q    <= 1'b0;
      xoff_active_q <= 1'b0;
      pause_sent_q  <= 1'b0;
      is_xon_q      <= 1'b0;
      quanta_q      <= 16'h0000;
      timer_q       <= 16'h0000;
    end else begin
      req_q         <= xoff_req;
      pause_sent_q  <= frame_done;
      xoff_active_q <= xoff_active_d;
      xoff_pend_q   <= cfg_tx_pause_enable & xoff_pend_d;
      xon_pend_q    <= cfg_tx_pause_enable & xon_pend_d;

      if (!cfg_tx_pause_enable)           timer_q <= 16'h0000;
      else if (frame_done && !is_xon_q)   timer_q <= cfg_refresh_count;
      else if (refresh_hit)               timer_q <= 16'h0000;
      else if (refresh_run && timer_q != 16'h0000) timer_q <= timer_q - 16'd1;

      if (launch) begin
        state_q  <= S_PAUSE;
        beat_q   <= 3'd0;
        is_xon_q <= xon_pend_d;
        quanta_q <= xon_pend_d ? 16'h0000 : cfg_pause_quanta;
      end else begin
        case (state_q)
          S_IDLE:  if (s_tvalid && m_tready && !s_tlast) state_q <= S_USER;
          S_USER:  if (s_tvalid && m_tready && s_tlast)  state_q <= S_IDLE;
          S_PAUSE: begin
            if (m_tready) begin
              beat_q <= beat_q + 3'd1;
              if (beat_q == 3'd7) state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign pause_sent  = pause_sent_q;
  assign xoff_active = xoff_active_q;

endmodule

// File: tb/tb_tx_pause_gen.sv
module tb_tx_pause_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid, s_tlast, s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid, m_tlast, m_tready;
  logic        xoff_req, cfg_tx_pause_enable;
  logic [47:0] cfg_src_mac;
  logic [15:0] cfg_pause_quanta, cfg_refresh_count;
  logic        pause_sent, xoff_active;

  tx_pause_gen dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .xoff_req(xoff_req), .cfg_tx_pause_enable(cfg_tx_pause_enable),
    .cfg_src_mac(cfg_src_mac), .cfg_pause_quanta(cfg_pause_quanta),
    .cfg_refresh_count(cfg_refresh_count),
    .pause_sent(pause_sent), .xoff_active(xoff_active)
  );

  always #5 clk = ~clk;

  localparam int K_USER = 0;
  localparam int K_XOFF = 1;
  localparam int K_XON  = 2;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    int          kind;
    int          idx;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ps_count = 0;
  int          ps_cyc[$];
  int          user_acc = 0;
  int          pause_acc = 0;
  int          held = 0;
  logic        exp_ps = 1'b0;
  logic        exp_xa = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_d;
  logic [7:0]  prev_k;
  logic        prev_l;
  logic [63:0] cap_d[8];
  logic [7:0]  cap_k[8];
  logic        cap_l[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame built as a byte list in wire order, then cut into 8-byte beats.
  function automatic logic [63:0] pause_word(input int b, input logic [15:0] q, input logic [47:0] sa);
    logic [7:0]  fr[64];
    logic [63:0] w;
    for (int i = 0; i < 64; i++) fr[i] = 8'h00;
    fr[0] = 8'h01; fr[1] = 8'h80; fr[2] = 8'hC2; fr[3] = 8'h00; fr[4] = 8'h00; fr[5] = 8'h01;
    for (int i = 0; i < 6; i++) fr[6+i] = sa[47-8*i -: 8];
    fr[12] = 8'h88; fr[13] = 8'h08; fr[14] = 8'h00; fr[15] = 8'h01;
    fr[16] = q[15:8]; fr[17] = q[7:0];
    w = 64'h0;
    for (int n = 0; n < 8; n++) w[8*n +: 8] = fr[8*b+n];
    return w;
  endfunction

  function automatic logic [63:0] user_word(input int id, input int b);
    return {8'hC0, 8'(id), 8'h5A, 8'(b), 32'hDEAD_0000 + 32'(id * 16 + b)};
  endfunction

  task automatic push_pause(input int kind, input logic [15:0] q);
    beat_t e;
    for (int b = 0; b < 8; b++) begin
      e.d = pause_word(b, q, cfg_src_mac);
      e.k = (b == 7) ? 8'h0F : 8'hFF;
      e.l = (b == 7);
      e.kind = kind;
      e.idx = b;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_user(input int id, input int b, input int len);
    s_tdata  = user_word(id, b);
    s_tkeep  = (b == len - 1) ? 8'h3F : 8'hFF;
    s_tlast  = (b == len - 1);
    s_tvalid = 1'b1;
  endtask

  task automatic send_frame(input int id, input int len);
    beat_t e;
    int    b = 0;
    int    guard = 0;
    logic  hs;
    for (int i = 0; i < len; i++) begin
      e.d = user_word(id, i);
      e.k = (i == len - 1) ? 8'h3F : 8'hFF;
      e.l = (i == len - 1);
      e.kind = K_USER;
      e.idx = i;
      exp_q.push_back(e);
    end
    drive_user(id, 0, len);
    while (b < len) begin
      @(negedge clk);
      hs = s_tvalid && s_tready;
      @(posedge clk); #1;
      if (hs) b++;
      if (b < len) drive_user(id, b, len);
      guard++;
      if (guard > 500) begin
        checks++; errors++;
        $display("FAIL send_frame_timeout: id %0d sent %0d of %0d beats", id, b, len);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d beats still expected, required 0", name, exp_q.size());
    end
  endtask

  // Per-cycle comparison against the expected stream and flag model.
  always @(negedge clk) begin
    beat_t e;
    logic  nps;
    cyc++;
    if (rst) begin
      chk("rst_m_tvalid", 64'(m_tvalid), 64'h0);
      chk("rst_s_tready", 64'(s_tready), 64'h0);
      exp_q.delete();
      exp_ps = 1'b0;
      exp_xa = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("pause_sent", 64'(pause_sent), 64'(exp_ps));
      chk("xoff_active", 64'(xoff_active), 64'(exp_xa));
      if (pause_sent) begin
        ps_count++;
        ps_cyc.push_back(cyc);
      end
      if (prev_stall) begin
        chk("stall_tvalid", 64'(m_tvalid), 64'h1);
        chk("stall_tdata", m_tdata, prev_d);
        chk("stall_tkeep_tlast", {55'h0, m_tlast, m_tkeep}, {55'h0, prev_l, prev_k});
      end
      nps = 1'b0;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got tdata %h, required no beat", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_tdata", m_tdata, e.d);
          chk("beat_tkeep_tlast", {55'h0, m_tlast, m_tkeep}, {55'h0, e.l, e.k});
          if (e.kind == K_USER) begin
            user_acc++;
          end else begin
            pause_acc++;
            cap_d[e.idx] = m_tdata;
            cap_k[e.idx] = m_tkeep;
            cap_l[e.idx] = m_tlast;
            if (e.l) begin
              nps = 1'b1;
              exp_xa = (e.kind == K_XOFF);
            end
          end
        end
      end
      exp_ps = nps;
      if (s_tvalid && !s_tready) held++;
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_k = m_tkeep;
      prev_l = m_tlast;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, g;
    rst = 1'b1;
    s_tdata = 64'h0; s_tkeep = 8'h0; s_tvalid = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1;
    xoff_req = 1'b0;
    cfg_tx_pause_enable = 1'b1;
    cfg_src_mac = 48'h0011_2233_4455;
    cfg_pause_quanta = 16'h1234;
    cfg_refresh_count = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cycles(3);
    @(negedge clk);
    chk("reset_xoff_active", 64'(xoff_active), 64'h0);
    chk("reset_m_tvalid", 64'(m_tvalid), 64'h0);
    @(posedge clk); #1;

    // Idle link XOFF
    push_pause(K_XOFF, 16'h1234);
    xoff_req = 1'b1;
    wait_empty(50, "xoff1");
    cycles(2);
    @(negedge clk);
    chk("b0_da_type", cap_d[0][47:0], 64'h0100_00C2_8001);
    chk("b0_sa01", cap_d[0][63:48], 64'h1100);
    chk("b1_hi", cap_d[1][63:32], 64'h0100_0888);
    chk("b1_sa25", cap_d[1][31:0], 64'h5544_3322);
    chk("b2_quanta", cap_d[2][15:0], 64'h3412);
    chk("b7_tkeep", cap_k[7], 64'h0F);
    chk("b7_tlast", 64'(cap_l[7]), 64'h1);
    chk("xoff1_active", 64'(xoff_active), 64'h1);
    chk("xoff1_pulses", ps_count, 1);
    @(posedge clk); #1;

    push_pause(K_XON, 16'h0000);
    xoff_req = 1'b0;
    wait_empty(50, "xon1");
    cycles(2);

    // Request rises mid user frame; next frame is held for the pause frame
    held = 0;
    user_acc = 0;
    fork
      begin
        send_frame(1, 10);
        send_frame(2, 3);
      end
      begin
        g = 0;
        while (user_acc < 3 && g < 200) begin
          @(posedge clk); #1;
          g++;
        end
        push_pause(K_XOFF, 16'h1234);
        xoff_req = 1'b1;
      end
    join
    wait_empty(100, "midframe");
    cycles(2);
    @(negedge clk);
    chk("midframe_held_cycles", held, 8);
    chk("midframe_user_beats", user_acc, 13);
    @(posedge clk); #1;

    // Refresh while held, then XON
    push_pause(K_XON, 16'h0000);
    xoff_req = 1'b0;
    wait_empty(50, "xon2");
    cycles(2);
    cfg_refresh_count = 16'd100;
    ps_cyc.delete();
    push_pause(K_XOFF, 16'h1234);
    push_pause(K_XOFF, 16'h1234);
    push_pause(K_XOFF, 16'h1234);
    xoff_req = 1'b1;
    wait_empty(400, "refresh");
    push_pause(K_XON, 16'h0000);
    xoff_req = 1'b0;
    wait_empty(50, "xon3");
    cycles(2);
    @(negedge clk);
    chk("refresh_pulses", ps_cyc.size(), 4);
    if (ps_cyc.size() >= 3) begin
      chk("refresh_gap1_in_range", 64'((ps_cyc[1] - ps_cyc[0]) >= 108 && (ps_cyc[1] - ps_cyc[0]) <= 110), 64'h1);
      chk("refresh_gap2_in_range", 64'((ps_cyc[2] - ps_cyc[1]) >= 108 && (ps_cyc[2] - ps_cyc[1]) <= 110), 64'h1);
    end
    chk("xon_quanta", cap_d[2][15:0], 64'h0);
    chk("xon_active", 64'(xoff_active), 64'h0);
    @(posedge clk); #1;
    cfg_refresh_count = 16'h0000;

    // One-cycle pulse with no XOFF outstanding: nothing emitted
    base = ps_count;
    xoff_req = 1'b1;
    cycles(1);
    xoff_req = 1'b0;
    cycles(30);
    @(negedge clk);
    chk("pulse_no_frame", ps_count, base);
    chk("pulse_xoff_active", 64'(xoff_active), 64'h0);
    @(posedge clk); #1;

    // Random backpressure during an XOFF frame
    pause_acc = 0;
    fork
      begin
        repeat (60) begin
          m_tready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        m_tready = 1'b1;
      end
      begin
        push_pause(K_XOFF, 16'h1234);
        xoff_req = 1'b1;
        wait_empty(200, "stall");
      end
    join
    m_tready = 1'b1;
    cycles(2);
    @(negedge clk);
    chk("stall_beats", pause_acc, 8);
    chk("stall_quanta", cap_d[2][15:0], 64'h3412);
    @(posedge clk); #1;
    push_pause(K_XON, 16'h0000);
    xoff_req = 1'b0;
    wait_empty(50, "xon4");
    cycles(2);

    // Disabled: toggling request gives pure pass-through
    cfg_tx_pause_enable = 1'b0;
    base = ps_count;
    held = 0;
    user_acc = 0;
    fork
      send_frame(3, 6);
      begin
        repeat (4) begin
          xoff_req = ~xoff_req;
          cycles(2);
        end
      end
    join
    cycles(20);
    cfg_tx_pause_enable = 1'b1;
    cycles(20);
    @(negedge clk);
    chk("disabled_no_frame", ps_count, base);
    chk("disabled_held", held, 0);
    chk("disabled_user_beats", user_acc, 6);
    @(posedge clk); #1;
    wait_empty(5, "disabled");

    // Reset in the middle of an XON frame
    push_pause(K_XOFF, 16'h1234);
    xoff_req = 1'b1;
    wait_empty(50, "xoff_pre_rst");
    cycles(2);
    pause_acc = 0;
    push_pause(K_XON, 16'h0000);
    xoff_req = 1'b0;
    g = 0;
    while (pause_acc < 3 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    rst = 1'b1;
    xoff_req = 1'b1;
    @(negedge clk);
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'h0);
    chk("midrst_s_tready", 64'(s_tready), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrst_pause_sent", 64'(pause_sent), 64'h0);
    chk("postrst_xoff_active", 64'(xoff_active), 64'h0);
    chk("postrst_m_tvalid", 64'(m_tvalid), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_pause(K_XOFF, 16'h1234);
    wait_empty(50, "xoff_after_rst");
    cycles(2);
    @(negedge clk);
    chk("after_rst_xoff_active", 64'(xoff_active), 64'h1);
    @(posedge clk); #1;
    push_pause(K_XON, 16'h0000);
    xoff_req = 1'b0;
    wait_empty(50, "xon_final");
    cycles(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
